sindoku_ctrl: RTL and testbench

SINDOKU_CTRL -- requirements
Module: sindoku_ctrl

---
 rtl/sindoku_pkg.sv | 28 ++
 rtl/sindoku_cursor.sv | 44 ++++
 rtl/sindoku_ctrl.sv | 150 +++++++++++++++
 tb/tb_sindoku_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sindoku_pkg.sv
// Shared definitions for the sindoku board controller.
// Holds the board geometry, the one-hot state encoding and the helper
// that turns a (row, col) cursor position into a flat cell address.
package sindoku_pkg;

    localparam int BOARD_DIM = 9;
    localparam int CELLS     = BOARD_DIM * BOARD_DIM;
    localparam int ADDR_W    = 7;

    // Highest legal row/column index; the cursor saturates here.
    localparam logic [3:0] MAX_IDX = 4'(BOARD_DIM - 1);

    // One-hot encoding so each state bit can drive its indicator directly.
    typedef enum logic [4:0] {
        ST_EDIT      = 5'b00001,
        ST_WRCHK     = 5'b00010,
        ST_CHKRD     = 5'b00100,
        ST_CORRECT   = 5'b01000,
        ST_INCORRECT = 5'b10000
    } state_t;

    // Flat cell address: row * 9 + col, range 0..80 for legal positions.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [3:0] row,
                                                    input logic [3:0] col);
        return 7'(row) * 7'(BOARD_DIM) + 7'(col);
    endfunction

endpackage

// File: rtl/sindoku_cursor.sv
// Cursor position register for the sindoku board.
// Ports:
//   Clk, Reset          clock and asynchronous active-high reset
//   move_en             moves are honoured only while this is high
//   move_up/down/left/right  single-cycle move requests
//   row, col            registered cursor position, 0..8
//   addr                row*9+col, derived combinationally from the registers
module sindoku_cursor
    import sindoku_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              move_en,
    input  logic              move_up,
    input  logic              move_down,
    input  logic              move_left,
    input  logic              move_right,
    output logic [3:0]        row,
    output logic [3:0]        col,
    output logic [ADDR_W-1:0] addr
);

    // Only one move is applied per cycle, priority up > down > left > right.
    // A move against an edge leaves the position unchanged (no wrap).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            row <= 4'd0;
            col <= 4'd0;
        end else if (move_en) begin
            if (move_up) begin
                if (row != 4'd0) row <= row - 4'd1;
            end else if (move_down) begin
                if (row != MAX_IDX) row <= row + 4'd1;
            end else if (move_left) begin
                if (col != 4'd0) col <= col - 4'd1;
            end else if (move_right) begin
                if (col != MAX_IDX) col <= col + 4'd1;
            end
        end
    end

    assign addr = cell_addr(row, col);

endmodule

// File: rtl/sindoku_ctrl.sv
// Sindoku board controller: cursor editing, guarded cell commits and a
// sequential full-board check against a solution ROM.
// Ports:
//   Clk, Reset                 clock and asynchronous active-high reset
//   BtnR/L/U/D/C               single-cycle button pulses (move / commit)
//   CheckReq, Ack              start a board check / clear a check result
//   UserVal                    value to commit (0 clears, 1..9 digits)
//   MemAddr/MemWe/MemWdata     board RAM port, address shared with both ROMs
//   MemRdata, GivenRd, SolRdata  RAM / given flag / solution, one-cycle latency
//   CurRow, CurCol             cursor position
//   Rejected                   one-cycle pulse when a commit is refused
//   ErrAddr                    first mismatching cell of the last failed check
//   q_Edit ... q_Incorrect     one-hot state indicators
module sindoku_ctrl
    import sindoku_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              BtnR,
    input  logic              BtnL,
    input  logic              BtnU,
    input  logic              BtnD,
    input  logic              BtnC,
    input  logic              CheckReq,
    input  logic              Ack,
    input  logic [3:0]        UserVal,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWe,
    output logic [3:0]        MemWdata,
    input  logic [3:0]        MemRdata,
    input  logic              GivenRd,
    input  logic [3:0]        SolRdata,
    output logic [3:0]        CurRow,
    output logic [3:0]        CurCol,
    output logic              Rejected,
    output logic [ADDR_W-1:0] ErrAddr,
    output logic              q_Edit,
    output logic              q_Wr,
    output logic              q_Chk,
    output logic              q_Correct,
    output logic              q_Incorrect
);

    state_t            state, next_state;
    logic [ADDR_W-1:0] scan_k;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] cur_addr;
    logic [3:0]        wr_val;
    logic [ADDR_W-1:0] err_addr_q;
    logic              rejected_q;
    logic              mismatch;
    logic              move_en;

    // Cursor moves only in EDIT and only when neither a check nor a commit
    // claims the cycle.
    assign move_en = (state == ST_EDIT) && !CheckReq && !BtnC;

    sindoku_cursor u_cursor (
        .Clk        (Clk),
        .Reset      (Reset),
        .move_en    (move_en),
        .move_up    (BtnU),
        .move_down  (BtnD),
        .move_left  (BtnL),
        .move_right (BtnR),
        .row        (CurRow),
        .col        (CurCol),
        .addr       (cur_addr)
    );

    // Data returned this cycle belongs to address scan_k-1; a blank cell
    // never matches a solution digit.
    assign mismatch = (MemRdata == 4'd0) || (MemRdata != SolRdata);

    // The final scan cycle (k = 81) has no new cell to fetch, so hold the
    // address at the last cell rather than leaving the board range.
    assign scan_addr = (scan_k == 7'(CELLS)) ? 7'(CELLS - 1) : scan_k;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_EDIT;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_EDIT: begin
                if (CheckReq)                      next_state = ST_CHKRD;
                else if (BtnC && UserVal <= 4'd9)  next_state = ST_WRCHK;
            end
            ST_WRCHK:
                next_state = ST_EDIT;
            ST_CHKRD: begin
                if (scan_k != '0) begin
                    if (mismatch)                   next_state = ST_INCORRECT;
                    else if (scan_k == 7'(CELLS))   next_state = ST_CORRECT;
                end
            end
            ST_CORRECT, ST_INCORRECT: begin
                if (Ack) next_state = ST_EDIT;
            end
            default:
                next_state = ST_EDIT;
        endcase
    end

    always_comb begin
        MemAddr     = (state == ST_CHKRD) ? scan_addr : cur_addr;
        MemWe       = (state == ST_WRCHK) && !GivenRd;
        MemWdata    = wr_val;
        Rejected    = rejected_q;
        ErrAddr     = err_addr_q;
        q_Edit      = (state == ST_EDIT);
        q_Wr        = (state == ST_WRCHK);
        q_Chk       = (state == ST_CHKRD);
        q_Correct   = (state == ST_CORRECT);
        q_Incorrect = (state == ST_INCORRECT);
    end

    // Commit value latch, scan counter, error address and reject pulse.
    // The scan counter is parked at 0 in EDIT so a check always starts at k=0.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            scan_k     <= '0;
            wr_val     <= 4'd0;
            err_addr_q <= '0;
            rejected_q <= 1'b0;
        end else begin
            rejected_q <= 1'b0;
            unique case (state)
                ST_EDIT: begin
                    scan_k <= '0;
                    if (!CheckReq && BtnC) begin
                        if (UserVal > 4'd9) rejected_q <= 1'b1;
                        else                wr_val     <= UserVal;
                    end
                end
                ST_WRCHK: begin
                    if (GivenRd) rejected_q <= 1'b1;
                end
                ST_CHKRD: begin
                    scan_k <= scan_k + 7'd1;
                    if (scan_k != '0 && mismatch) err_addr_q <= scan_k - 7'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sindoku_ctrl.sv
// Self-checking bench for sindoku_ctrl. Board RAM, given-flag ROM and
// solution ROM are modelled here with one-cycle read latency. Expected
// output events (writes, rejects, check results) are queued when stimulus
// is issued and matched by a monitor as the DUT produces them.
module tb_sindoku_ctrl;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       BtnR, BtnL, BtnU, BtnD, BtnC, CheckReq, Ack;
    logic [3:0] UserVal;
    logic [6:0] MemAddr;
    logic       MemWe;
    logic [3:0] MemWdata;
    logic [3:0] MemRdata;
    logic       GivenRd;
    logic [3:0] SolRdata;
    logic [3:0] CurRow, CurCol;
    logic       Rejected;
    logic [6:0] ErrAddr;
    logic       q_Edit, q_Wr, q_Chk, q_Correct, q_Incorrect;

    localparam logic [6:0] B_R   = 7'b0000001;
    localparam logic [6:0] B_L   = 7'b0000010;
    localparam logic [6:0] B_D   = 7'b0000100;
    localparam logic [6:0] B_U   = 7'b0001000;
    localparam logic [6:0] B_C   = 7'b0010000;
    localparam logic [6:0] B_CHK = 7'b0100000;
    localparam logic [6:0] B_ACK = 7'b1000000;

    localparam int EV_WRITE = 1;
    localparam int EV_REJ   = 2;
    localparam int EV_OK    = 3;
    localparam int EV_BAD   = 4;

    typedef struct {
        int kind;
        int addr;
        int data;
    } evt_t;

    evt_t expQ[$];
    int   compared   = 0;
    int   mismatched = 0;

    logic [3:0] ram[81];
    logic [3:0] ramInit[81];
    logic [3:0] sol[81];
    logic       given[81];
    logic       loadRam = 1'b0;
    logic [6:0] memIdx;
    logic       prevOk = 1'b0;
    logic       prevBad = 1'b0;

    sindoku_ctrl dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .BtnR        (BtnR),
        .BtnL        (BtnL),
        .BtnU        (BtnU),
        .BtnD        (BtnD),
        .BtnC        (BtnC),
        .CheckReq    (CheckReq),
        .Ack         (Ack),
        .UserVal     (UserVal),
        .MemAddr     (MemAddr),
        .MemWe       (MemWe),
        .MemWdata    (MemWdata),
        .MemRdata    (MemRdata),
        .GivenRd     (GivenRd),
        .SolRdata    (SolRdata),
        .CurRow      (CurRow),
        .CurCol      (CurCol),
        .Rejected    (Rejected),
        .ErrAddr     (ErrAddr),
        .q_Edit      (q_Edit),
        .q_Wr        (q_Wr),
        .q_Chk       (q_Chk),
        .q_Correct   (q_Correct),
        .q_Incorrect (q_Incorrect)
    );

    // Free-running clock, 10 time units per period.
    always #5 Clk = ~Clk;

    assign memIdx = (MemAddr > 7'd80) ? 7'd80 : MemAddr;

    // Memory models: synchronous read with one cycle of latency. A bulk load
    // from ramInit lets the stimulus reshape the board between checks.
    always @(posedge Clk) begin
        if (loadRam) begin
            for (int i = 0; i < 81; i++) ram[i] <= ramInit[i];
        end else if (MemWe) begin
            ram[memIdx] <= MemWdata;
        end
        MemRdata <= ram[memIdx];
        GivenRd  <= given[memIdx];
        SolRdata <= sol[memIdx];
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic scoreEvt(input int kind, input int addr, input int data);
        evt_t e;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected event: got kind %0d addr %0d data %0d, expected none",
                     kind, addr, data);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data) begin
                mismatched++;
                $display("[TB] FAIL event: got kind %0d addr %0d data %0d, expected kind %0d addr %0d data %0d",
                         kind, addr, data, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic pushEvt(input int kind, input int addr, input int data);
        evt_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        expQ.push_back(e);
    endtask

    // Monitor: samples on the falling edge, turns every write, reject pulse
    // and new check result into an event and scores it against the queue.
    always @(negedge Clk) begin
        if (Reset) begin
            prevOk  = 1'b0;
            prevBad = 1'b0;
        end else begin
            if (MemWe)                   scoreEvt(EV_WRITE, int'(MemAddr), int'(MemWdata));
            if (Rejected)                scoreEvt(EV_REJ, 0, 0);
            if (q_Correct && !prevOk)    scoreEvt(EV_OK, 0, 0);
            if (q_Incorrect && !prevBad) scoreEvt(EV_BAD, int'(ErrAddr), 0);
            prevOk  = q_Correct;
            prevBad = q_Incorrect;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] btns, input logic [3:0] val);
        {Ack, CheckReq, BtnC, BtnU, BtnD, BtnL, BtnR} = btns;
        UserVal = val;
        tick();
        {Ack, CheckReq, BtnC, BtnU, BtnD, BtnL, BtnR} = '0;
    endtask

    task automatic loadBoard();
        loadRam = 1'b1;
        tick();
        loadRam = 1'b0;
    endtask

    // Counts clock edges until a check result shows, bounded at 200. With
    // poke set, buttons, commit and Ack are pulsed mid-scan to be ignored.
    task automatic waitResult(input bit poke, output int cycles);
        cycles = 0;
        while (!(q_Correct || q_Incorrect) && cycles < 200) begin
            if (poke && cycles == 10) {BtnR, BtnC, Ack} = 3'b111;
            tick();
            {BtnR, BtnC, Ack} = 3'b000;
            cycles++;
        end
    endtask

    // Hard stop in case something upstream never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cycles;
        int n;
        {Ack, CheckReq, BtnC, BtnU, BtnD, BtnL, BtnR} = '0;
        UserVal = 4'd0;
        Reset   = 1'b1;
        for (int i = 0; i < 81; i++) begin
            sol[i]     = 4'((i % 9) + 1);
            ramInit[i] = 4'((i % 9) + 1);
            given[i]   = 1'b0;
        end
        given[22] = 1'b1;
        repeat (2) tick();
        loadBoard();
        Reset = 1'b0;
        tick();

        // Reset state
        checkOutput("reset q_Edit", int'(q_Edit), 1);
        checkOutput("reset one-hot", int'(q_Edit) + int'(q_Wr) + int'(q_Chk) + int'(q_Correct) + int'(q_Incorrect), 1);
        checkOutput("reset CurRow", int'(CurRow), 0);
        checkOutput("reset CurCol", int'(CurCol), 0);
        checkOutput("reset MemAddr", int'(MemAddr), 0);
        checkOutput("reset MemWe", int'(MemWe), 0);
        checkOutput("reset Rejected", int'(Rejected), 0);
        checkOutput("reset ErrAddr", int'(ErrAddr), 0);

        // Right saturates at column 8
        for (int i = 1; i <= 9; i++) begin
            applyStimulus(B_R, 4'd0);
            if (i == 8) checkOutput("col after 8 right", int'(CurCol), 8);
        end
        checkOutput("col after 9 right", int'(CurCol), 8);
        checkOutput("edit after saturate", int'(q_Edit), 1);
        checkOutput("MemAddr at (0,8)", int'(MemAddr), 8);
        for (int i = 0; i < 8; i++) applyStimulus(B_L, 4'd0);
        checkOutput("col after 8 left", int'(CurCol), 0);
        applyStimulus(B_L, 4'd0);
        checkOutput("left at col 0", int'(CurCol), 0);
        applyStimulus(B_U, 4'd0);
        checkOutput("up at row 0", int'(CurRow), 0);

        // Move priorities: left beats right, up beats down
        applyStimulus(B_L | B_R, 4'd0);
        checkOutput("left beats right", int'(CurCol), 0);
        applyStimulus(B_U | B_D, 4'd0);
        checkOutput("up beats down", int'(CurRow), 0);

        // Walk to (2,3) -> address 21
        applyStimulus(B_D, 4'd0);
        applyStimulus(B_D, 4'd0);
        for (int i = 0; i < 3; i++) applyStimulus(B_R, 4'd0);
        checkOutput("row at (2,3)", int'(CurRow), 2);
        checkOutput("MemAddr at (2,3)", int'(MemAddr), 21);

        // Commit 7 to a free cell
        pushEvt(EV_WRITE, 21, 7);
        applyStimulus(B_C, 4'd7);
        checkOutput("commit in WRCHK", int'(q_Wr), 1);
        tick();
        checkOutput("commit back to EDIT", int'(q_Edit), 1);

        // Commit to a given cell (2,4) is refused
        applyStimulus(B_R, 4'd0);
        pushEvt(EV_REJ, 0, 0);
        applyStimulus(B_C, 4'd5);
        checkOutput("given in WRCHK", int'(q_Wr), 1);
        tick();
        checkOutput("given Rejected pulse", int'(Rejected), 1);
        checkOutput("given back to EDIT", int'(q_Edit), 1);

        // Illegal value: rejected right away, commit beats the up move
        pushEvt(EV_REJ, 0, 0);
        applyStimulus(B_C | B_U, 4'd12);
        checkOutput("illegal stays EDIT", int'(q_Edit), 1);
        checkOutput("illegal Rejected", int'(Rejected), 1);
        checkOutput("illegal no move", int'(CurRow), 2);
        tick();
        checkOutput("Rejected one cycle", int'(Rejected), 0);

        // Full correct board; CheckReq beats BtnC, pokes during scan ignored
        loadBoard();
        pushEvt(EV_OK, 0, 0);
        applyStimulus(B_CHK | B_C, 4'd3);
        checkOutput("check entered CHKRD", int'(q_Chk), 1);
        checkOutput("scan starts at 0", int'(MemAddr), 0);
        waitResult(1'b1, cycles);
        checkOutput("correct latency", cycles, 82);
        checkOutput("q_Correct", int'(q_Correct), 1);
        checkOutput("col unchanged by scan", int'(CurCol), 4);
        applyStimulus(B_L | B_C, 4'd2);
        checkOutput("CORRECT holds", int'(q_Correct), 1);
        checkOutput("buttons ignored in CORRECT", int'(CurCol), 4);
        applyStimulus(B_ACK, 4'd0);
        checkOutput("Ack to EDIT", int'(q_Edit), 1);
        checkOutput("cursor kept row", int'(CurRow), 2);
        checkOutput("cursor kept col", int'(CurCol), 4);

        // Mismatch at address 40 only
        ramInit[40] = 4'd6;
        loadBoard();
        pushEvt(EV_BAD, 40, 0);
        applyStimulus(B_CHK, 4'd0);
        waitResult(1'b0, cycles);
        checkOutput("incorrect latency @40", cycles, 42);
        checkOutput("q_Incorrect @40", int'(q_Incorrect), 1);
        checkOutput("ErrAddr @40", int'(ErrAddr), 40);
        applyStimulus(B_ACK, 4'd0);
        checkOutput("Ack from INCORRECT", int'(q_Edit), 1);

        // Reset in the middle of a scan at address 50
        ramInit[40] = 4'd5;
        loadBoard();
        applyStimulus(B_CHK, 4'd0);
        n = 0;
        while (MemAddr != 7'd50 && n < 100) begin
            tick();
            n++;
        end
        checkOutput("scan reached 50", int'(MemAddr), 50);
        Reset = 1'b1;
        #1;
        checkOutput("mid-scan reset q_Edit", int'(q_Edit), 1);
        checkOutput("mid-scan reset q_Chk", int'(q_Chk), 0);
        checkOutput("mid-scan reset CurRow", int'(CurRow), 0);
        checkOutput("mid-scan reset CurCol", int'(CurCol), 0);
        checkOutput("mid-scan reset MemWe", int'(MemWe), 0);
        checkOutput("mid-scan reset ErrAddr", int'(ErrAddr), 0);
        repeat (2) tick();
        Reset = 1'b0;
        repeat (90) tick();
        checkOutput("no scan resume", int'(q_Edit), 1);

        // Blank first cell
        ramInit[0] = 4'd0;
        loadBoard();
        pushEvt(EV_BAD, 0, 0);
        applyStimulus(B_CHK, 4'd0);
        waitResult(1'b0, cycles);
        checkOutput("incorrect latency @0", cycles, 2);
        checkOutput("ErrAddr blank @0", int'(ErrAddr), 0);
        checkOutput("q_Incorrect blank", int'(q_Incorrect), 1);
        applyStimulus(B_ACK, 4'd0);
        tick();

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
